// File: rtl/vnet_local_inject_ni.sv
// Injection network interface for one vnet_router local port: a single-entry hold
// stage, XY look-ahead route, round-robin VC choice and per-VC credit counters.
module vnet_local_inject_ni #(
    parameter int VC_NUM         = 4,
    parameter int VC_DEPTH       = 4,
    parameter int VC_ID_W        = 3,
    parameter int FLIT_W         = 128,
    parameter int NODE_X_W       = 2,
    parameter int NODE_Y_W       = 2,
    parameter int LOCAL_PORT_NUM = 1,
    parameter int ROUTE_W        = 3
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              req_v_i,
    output logic                              req_rdy_o,
    input  logic [FLIT_W-1:0]                 req_flit_i,
    input  logic [NODE_X_W-1:0]               req_dst_x_i,
    input  logic [NODE_Y_W-1:0]               req_dst_y_i,
    input  logic [$clog2(LOCAL_PORT_NUM):0]   req_dst_port_i,
    input  logic [NODE_X_W-1:0]               node_id_x_i,
    input  logic [NODE_Y_W-1:0]               node_id_y_i,
    output logic                              tx_flit_pend_o,
    output logic                              tx_flit_v_o,
    output logic [FLIT_W-1:0]                 tx_flit_o,
    output logic [VC_ID_W-1:0]                tx_flit_vc_id_o,
    output logic [ROUTE_W-1:0]                tx_flit_look_ahead_routing_o,
    input  logic                              rx_lcrd_v_i,
    input  logic [VC_ID_W-1:0]                rx_lcrd_id_i,
    output logic                              credit_err_o
);

    localparam int VC_PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CRD_W    = $clog2(VC_DEPTH + 1);

    localparam logic [ROUTE_W-1:0] ROUTE_N    = ROUTE_W'(0);
    localparam logic [ROUTE_W-1:0] ROUTE_S    = ROUTE_W'(1);
    localparam logic [ROUTE_W-1:0] ROUTE_E    = ROUTE_W'(2);
    localparam logic [ROUTE_W-1:0] ROUTE_W_   = ROUTE_W'(3);
    localparam logic [ROUTE_W-1:0] ROUTE_LOC0 = ROUTE_W'(4);

    logic                 hold_v;
    logic [FLIT_W-1:0]    hold_flit;
    logic [ROUTE_W-1:0]   hold_route;
    logic [ROUTE_W-1:0]   req_route;
    logic [VC_PTR_W-1:0]  rr_ptr;
    logic [VC_PTR_W-1:0]  rr_nxt;
    logic [VC_PTR_W-1:0]  pick_vc;
    logic [VC_PTR_W-1:0]  scan_idx;
    logic                 pick_found;
    logic                 send;
    logic                 accept;
    logic [CRD_W-1:0]     credit     [VC_NUM];
    logic [CRD_W-1:0]     credit_nxt [VC_NUM];
    logic [VC_NUM-1:0]    crd_dec;
    logic [VC_NUM-1:0]    crd_inc;
    logic                 crd_id_legal;
    logic                 crd_err_set;

    // XY routing: resolve X first, then Y, then eject to the addressed local port.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        req_route = ROUTE_LOC0 + ROUTE_W'(req_dst_port_i);
        if (req_dst_x_i > node_id_x_i)      req_route = ROUTE_E;
        else if (req_dst_x_i < node_id_x_i) req_route = ROUTE_W_;
        else if (req_dst_y_i > node_id_y_i) req_route = ROUTE_N;
        else if (req_dst_y_i < node_id_y_i) req_route = ROUTE_S;
    end

    always_comb begin
        pick_found = 1'b0;
        pick_vc    = '0;
        scan_idx   = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            scan_idx = VC_PTR_W'((int'(rr_ptr) + i) % VC_NUM);
            if (!pick_found && (credit[scan_idx] != '0)) begin
                pick_found = 1'b1;
                pick_vc    = scan_idx;
            end
        end
    end

    assign send      = hold_v && pick_found;
    assign req_rdy_o = !hold_v || send;
    assign accept    = req_v_i && req_rdy_o;
    assign rr_nxt    = (pick_vc == VC_PTR_W'(VC_NUM - 1)) ? '0 : pick_vc + VC_PTR_W'(1);

    assign crd_id_legal = (32'(rx_lcrd_id_i) < 32'(VC_NUM));

    always_comb begin
        crd_dec = '0;
        crd_inc = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            crd_dec[v] = send && (pick_vc == VC_PTR_W'(v));
            crd_inc[v] = rx_lcrd_v_i && crd_id_legal && (rx_lcrd_id_i == VC_ID_W'(v));
        end
    end

    // A simultaneous send and return on one VC cancel; a return to a full VC saturates and flags.
    always_comb begin
        crd_err_set = rx_lcrd_v_i && !crd_id_legal;
        for (int v = 0; v < VC_NUM; v++) begin
            credit_nxt[v] = credit[v];
            if (crd_dec[v] && !crd_inc[v]) begin
                credit_nxt[v] = credit[v] - CRD_W'(1);
            end else if (crd_inc[v] && !crd_dec[v]) begin
                if (credit[v] == CRD_W'(VC_DEPTH)) crd_err_set = 1'b1;
                else                               credit_nxt[v] = credit[v] + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_v                       <= 1'b0;
            rr_ptr                       <= '0;
            credit_err_o                 <= 1'b0;
            tx_flit_v_o                  <= 1'b0;
            tx_flit_pend_o               <= 1'b0;
            tx_flit_o                    <= '0;
            tx_flit_vc_id_o              <= '0;
            tx_flit_look_ahead_routing_o <= '0;
            for (int v = 0; v < VC_NUM; v++) credit[v] <= CRD_W'(VC_DEPTH);
        end else begin
            // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
            credit_err_o   <= credit_err_o | crd_err_set;
            tx_flit_v_o    <= send;
            tx_flit_pend_o <= hold_v && !send;
            if (accept)    hold_v <= 1'b1;
            else if (send) hold_v <= 1'b0;
            if (send) begin
                tx_flit_o                    <= hold_flit;
                tx_flit_vc_id_o              <= VC_ID_W'(pick_vc);
                tx_flit_look_ahead_routing_o <= hold_route;
                rr_ptr                       <= rr_nxt;
            end
            for (int v = 0; v < VC_NUM; v++) credit[v] <= credit_nxt[v];
        end
    end

    // NOTE: hold payload is pure datapath qualified by hold_v, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_flit  <= req_flit_i;
            hold_route <= req_route;
        end
    end

endmodule

// File: tb/tb_vnet_local_inject_ni.sv
// Self-checking bench for vnet_local_inject_ni: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_vnet_local_inject_ni;

    localparam int VC_NUM         = 4;
    localparam int VC_DEPTH       = 4;
    localparam int VC_ID_W        = 3;
    localparam int FLIT_W         = 128;
    localparam int NODE_X_W       = 2;
    localparam int NODE_Y_W       = 2;
    localparam int LOCAL_PORT_NUM = 1;
    localparam int ROUTE_W        = 3;
    localparam int OWN_X          = 1;
    localparam int OWN_Y          = 1;

    logic                            clk = 1'b0;
    logic                            rstn = 1'b1;
    logic                            req_v_i = 1'b0;
    logic                            req_rdy_o;
    logic [FLIT_W-1:0]               req_flit_i = '0;
    logic [NODE_X_W-1:0]             req_dst_x_i = '0;
    logic [NODE_Y_W-1:0]             req_dst_y_i = '0;
    logic [$clog2(LOCAL_PORT_NUM):0] req_dst_port_i = '0;
    logic [NODE_X_W-1:0]             node_id_x_i = NODE_X_W'(OWN_X);
    logic [NODE_Y_W-1:0]             node_id_y_i = NODE_Y_W'(OWN_Y);
    logic                            tx_flit_pend_o;
    logic                            tx_flit_v_o;
    logic [FLIT_W-1:0]               tx_flit_o;
    logic [VC_ID_W-1:0]              tx_flit_vc_id_o;
    logic [ROUTE_W-1:0]              tx_flit_look_ahead_routing_o;
    logic                            rx_lcrd_v_i = 1'b0;
    logic [VC_ID_W-1:0]              rx_lcrd_id_i = '0;
    logic                            credit_err_o;

    always #5 clk = ~clk;

    vnet_local_inject_ni #(
        .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .VC_ID_W(VC_ID_W), .FLIT_W(FLIT_W),
        .NODE_X_W(NODE_X_W), .NODE_Y_W(NODE_Y_W), .LOCAL_PORT_NUM(LOCAL_PORT_NUM),
        .ROUTE_W(ROUTE_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_v_i(req_v_i), .req_rdy_o(req_rdy_o), .req_flit_i(req_flit_i),
        .req_dst_x_i(req_dst_x_i), .req_dst_y_i(req_dst_y_i), .req_dst_port_i(req_dst_port_i),
        .node_id_x_i(node_id_x_i), .node_id_y_i(node_id_y_i),
        .tx_flit_pend_o(tx_flit_pend_o), .tx_flit_v_o(tx_flit_v_o), .tx_flit_o(tx_flit_o),
        .tx_flit_vc_id_o(tx_flit_vc_id_o),
        .tx_flit_look_ahead_routing_o(tx_flit_look_ahead_routing_o),
        .rx_lcrd_v_i(rx_lcrd_v_i), .rx_lcrd_id_i(rx_lcrd_id_i), .credit_err_o(credit_err_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: one waiting flit, a credit count per VC, the next VC to try first.
    bit                m_hold;
    logic [FLIT_W-1:0] m_hflit;
    int                m_hroute;
    int                m_cred [VC_NUM];
    int                m_rr;
    bit                m_err;
    bit                m_txv;
    logic [FLIT_W-1:0] m_txflit;
    int                m_txvc;
    int                m_txroute;
    bit                m_pend;

    int n_tx;
    int vc_log [$];

    task automatic check(input string tag, input logic [FLIT_W-1:0] got, input logic [FLIT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_route(input int dx, input int dy, input int port);
        if (dx > OWN_X) return 2;
        if (dx < OWN_X) return 3;
        if (dy > OWN_Y) return 0;
        if (dy < OWN_Y) return 1;
        return 4 + port;
    endfunction

    function automatic bit model_rdy();
        if (!m_hold) return 1'b1;
        for (int v = 0; v < VC_NUM; v++) if (m_cred[v] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_hflit = '0; m_hroute = 0; m_rr = 0; m_err = 0;
        m_txv = 0; m_txflit = '0; m_txvc = 0; m_txroute = 0; m_pend = 0;
        for (int v = 0; v < VC_NUM; v++) m_cred[v] = VC_DEPTH;
        n_tx = 0;
        vc_log.delete();
    endtask

    task automatic model_update();
        int pick;
        bit send;
        bit accept;
        int id;
        pick = -1;
        if (m_hold) begin
            for (int k = 0; k < VC_NUM; k++) begin
                int v;
                v = (m_rr + k) % VC_NUM;
                if (pick < 0 && m_cred[v] > 0) pick = v;
            end
        end
        send   = (pick >= 0);
        accept = req_v_i && (!m_hold || send);
        m_pend = m_hold && !send;
        m_txv  = send;
        if (send) begin
            m_txflit  = m_hflit;
            m_txvc    = pick;
            m_txroute = m_hroute;
            m_rr      = (pick + 1) % VC_NUM;
            m_cred[pick]--;
        end
        if (rx_lcrd_v_i) begin
            id = int'(rx_lcrd_id_i);
            if (id >= VC_NUM)                m_err = 1;
            else if (m_cred[id] >= VC_DEPTH) m_err = 1;
            else                             m_cred[id]++;
        end
        if (accept) begin
            m_hold   = 1;
            m_hflit  = req_flit_i;
            m_hroute = ref_route(int'(req_dst_x_i), int'(req_dst_y_i), int'(req_dst_port_i));
        end else if (send) begin
            m_hold = 0;
        end
    endtask

    task automatic compare();
        check("tx_v",   tx_flit_v_o, m_txv);
        check("pend",   tx_flit_pend_o, m_pend);
        check("rdy",    req_rdy_o, model_rdy());
        check("flit",   tx_flit_o, m_txflit);
        check("vc_id",  tx_flit_vc_id_o, m_txvc);
        check("route",  tx_flit_look_ahead_routing_o, m_txroute);
        check("crd_err", credit_err_o, m_err);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
        if (tx_flit_v_o === 1'b1) begin
            n_tx++;
            vc_log.push_back(int'(tx_flit_vc_id_o));
        end
    endtask

    task automatic do_reset();
        req_v_i     = 1'b0;
        rx_lcrd_v_i = 1'b0;
        rstn        = 1'b0;
        #1;
        check("rst_tx_v",  tx_flit_v_o, 0);
        check("rst_pend",  tx_flit_pend_o, 0);
        check("rst_rdy",   req_rdy_o, 1);
        check("rst_flit",  tx_flit_o, 0);
        check("rst_vc",    tx_flit_vc_id_o, 0);
        check("rst_route", tx_flit_look_ahead_routing_o, 0);
        check("rst_err",   credit_err_o, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic drive_req(input int x, input int y, input int p);
        req_v_i        = 1'b1;
        req_flit_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_dst_x_i    = NODE_X_W'(x);
        req_dst_y_i    = NODE_Y_W'(y);
        req_dst_port_i = p[0];
    endtask

    task automatic drive_rand_req();
        drive_req($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
    endtask

    int rt_x [4] = '{0, 1, 1, 1};
    int rt_y [4] = '{2, 2, 0, 1};
    int rt_r [4] = '{3, 0, 1, 4};

    initial begin
        #2;
        do_reset();
        compare();

        // First-hop east route, then a second flit on the next VC.
        drive_req(3, 1, 0);
        tick();
        req_v_i = 1'b0;
        tick();
        check("first_v", tx_flit_v_o, 1);
        check("first_route", tx_flit_look_ahead_routing_o, 2);
        check("first_vc", tx_flit_vc_id_o, 0);
        drive_req(3, 1, 0);
        tick();
        req_v_i = 1'b0;
        tick();
        check("second_vc", tx_flit_vc_id_o, 1);

        for (int i = 0; i < 4; i++) begin
            drive_req(rt_x[i], rt_y[i], 0);
            tick();
            req_v_i = 1'b0;
            tick();
            check("route_tbl_v", tx_flit_v_o, 1);
            check("route_tbl", tx_flit_look_ahead_routing_o, rt_r[i]);
        end

        // Exhaust all credits back to back; the 17th flit must stall.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_rand_req();
            tick();
        end
        check("exhaust_sends", n_tx, 16);
        for (int i = 0; i < 16; i++) check("exhaust_vc_seq", vc_log[i], i % VC_NUM);
        check("stall_pend", tx_flit_pend_o, 1);
        check("stall_rdy", req_rdy_o, 0);

        // One credit back on VC 2 releases the stalled flit onto VC 2.
        req_v_i      = 1'b0;
        rx_lcrd_v_i  = 1'b1;
        rx_lcrd_id_i = VC_ID_W'(2);
        tick();
        rx_lcrd_v_i = 1'b0;
        tick();
        check("release_v", tx_flit_v_o, 1);
        check("release_vc", tx_flit_vc_id_o, 2);
        check("release_pend", tx_flit_pend_o, 0);
        drive_rand_req();
        tick();
        req_v_i = 1'b0;
        tick();
        check("restall_pend", tx_flit_pend_o, 1);

        // Reset with a held flit and empty credits, then a full burst again.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive_rand_req();
            else        req_v_i = 1'b0;
            tick();
        end
        check("post_reset_sends", n_tx, 16);

        // Same-cycle send and return on VC 0, then overflow on VC 1.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_rand_req();
            tick();
        end
        req_v_i      = 1'b0;
        rx_lcrd_v_i  = 1'b1;
        rx_lcrd_id_i = VC_ID_W'(0);
        tick();
        check("same_cyc_v", tx_flit_v_o, 1);
        check("same_cyc_vc", tx_flit_vc_id_o, 0);
        rx_lcrd_id_i = VC_ID_W'(1);
        tick();
        check("vc1_refill_err", credit_err_o, 0);
        tick();
        rx_lcrd_v_i = 1'b0;
        check("vc1_overflow_err", credit_err_o, 1);
        n_tx = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) drive_rand_req();
            else        req_v_i = 1'b0;
            tick();
        end
        check("drain_sends", n_tx, 13);

        // Out-of-range credit id is flagged and sticks.
        do_reset();
        rx_lcrd_v_i  = 1'b1;
        rx_lcrd_id_i = VC_ID_W'($urandom_range(VC_NUM, (1 << VC_ID_W) - 1));
        tick();
        rx_lcrd_v_i = 1'b0;
        check("bad_id_err", credit_err_o, 1);
        tick();
        check("bad_id_sticky", credit_err_o, 1);

        // Random traffic with a router-like credit return from observed sends.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int c = 0; c < 750; c++) begin
                if ($urandom_range(0, 3) != 0) drive_rand_req();
                else                           req_v_i = 1'b0;
                rx_lcrd_v_i = 1'b0;
                if ($urandom_range(0, 299) == 0) begin
                    rx_lcrd_v_i  = 1'b1;
                    rx_lcrd_id_i = VC_ID_W'($urandom_range(0, (1 << VC_ID_W) - 1));
                end else if (vc_log.size() > 0 && $urandom_range(0, 1) == 1) begin
                    rx_lcrd_v_i  = 1'b1;
                    rx_lcrd_id_i = VC_ID_W'(vc_log.pop_front());
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
